// File: rtl/mac_psum_accumulator.sv
// rtl/mac_psum_accumulator.sv - partial-sum accumulation loop and requantizer behind the 8x8 MAC stage
// Optional feature: define PSUM_ROUND_EN for round-half-up requantization (default truncates).
module mac_psum_accumulator #(
  parameter int width    = 8,
  parameter int accwidth = 32,
  parameter int lenwidth = 16,
  parameter int shwidth  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [lenwidth-1:0] cfg_len,
  input  logic [shwidth-1:0]  cfg_shift,
  output logic                busy,
  input  logic                step_valid,
  output logic                step_ready,
  input  logic [accwidth-1:0] psum_from_mac,
  output logic [accwidth-1:0] psum_to_mac,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [width-1:0]    out_data,
  output logic                out_ovf
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [lenwidth-1:0] one_len  = 1;
  localparam logic [shwidth-1:0]  one_sh   = 1;
  localparam logic [accwidth:0]   one_wide = 1;

  state_t              state, state_next;
  logic [accwidth-1:0] acc;
  logic [lenwidth-1:0] cnt, len;
  logic [shwidth-1:0]  shift;
  logic                ovf;

  logic                last_step, ovf_next;
  logic [accwidth:0]   round_add, shifted;
  logic [width-1:0]    result;

  assign busy        = (state != IDLE);
  assign step_ready  = (state == ACC);
  assign out_valid   = (state == OUT);
  assign psum_to_mac = acc;

  // Product terms are non-negative, so a smaller new sum means the accumulator wrapped.
  assign last_step = (cnt == len - one_len);
  assign ovf_next  = ovf | (psum_from_mac < acc);

  // Requantize in accwidth+1 bits so the rounding carry is not lost.
  always_comb begin
    round_add = '0;
    shifted   = '0;
`ifdef PSUM_ROUND_EN
    if (shift != '0)
      round_add = one_wide << (shift - one_sh);
`endif
    if (32'(shift) >= accwidth) begin
`ifdef PSUM_ROUND_EN
      shifted = {{accwidth{1'b0}}, psum_from_mac[accwidth-1]};
`endif
    end else begin
      shifted = ({1'b0, psum_from_mac} + round_add) >> shift;
    end
    if (ovf_next || (|shifted[accwidth:width]))
      result = '1;
    else
      result = shifted[width-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (cfg_len != '0) ? ACC : OUT;
      ACC:     if (step_valid && last_step) state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      len      <= '0;
      shift    <= '0;
      ovf      <= 1'b0;
      out_data <= '0;
      out_ovf  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          len      <= cfg_len;
          shift    <= cfg_shift;
          acc      <= '0;
          cnt      <= '0;
          ovf      <= 1'b0;
          out_data <= '0;
          out_ovf  <= 1'b0;
        end
        ACC: if (step_valid) begin
          acc <= psum_from_mac;
          cnt <= cnt + one_len;
          ovf <= ovf_next;
          if (last_step) begin
            out_data <= result;
            out_ovf  <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_psum_accumulator.sv
// tb/tb_mac_psum_accumulator.sv - randomized self-checking bench for mac_psum_accumulator
module tb_mac_psum_accumulator;

  logic        clk = 1'b0;
  logic        rst, start, step_valid, out_ready;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic [31:0] psum_from_mac;
  logic        busy, step_ready, out_valid, out_ovf;
  logic [31:0] psum_to_mac;
  logic [7:0]  out_data;

  int errors = 0;
  int checks = 0;
  logic [63:0] terms[$];

  mac_psum_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_shift(cfg_shift),
    .busy(busy), .step_valid(step_valid), .step_ready(step_ready),
    .psum_from_mac(psum_from_mac), .psum_to_mac(psum_to_mac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The bench plays the MAC: each step presents running sum + term from its own model.
  task automatic run_accum(input logic [15:0] k, input logic [4:0] sh);
    logic [63:0] sum;
    logic [31:0] macc;
    logic [63:0] q;
    logic [7:0]  exp_data;
    logic        exp_ovf;
    int          n;
    sum  = 0;
    macc = 0;
    start = 1'b1; cfg_len = k; cfg_shift = sh;
    tick();
    start = 1'b0; cfg_len = 16'($urandom); cfg_shift = 5'($urandom);
    check("busy_after_start", busy, 1);
    check("step_ready_after_start", step_ready, k != 0);
    check("out_valid_after_start", out_valid, k == 0);
    check("psum_cleared", psum_to_mac, 0);
    for (int i = 0; i < k; i++) begin
      n = $urandom_range(0, 2);
      for (int s = 0; s < n; s++) begin
        step_valid = 1'b0; psum_from_mac = $urandom;
        tick();
        check("stall_hold", psum_to_mac, macc);
      end
      step_valid = 1'b1;
      psum_from_mac = macc + terms[i][31:0];
      check("psum_to_mac", psum_to_mac, macc);
      check("step_ready", step_ready, 1);
      tick();
      sum  = sum + {32'd0, terms[i][31:0]};
      macc = sum[31:0];
    end
    step_valid = 1'b0;

    exp_ovf = (sum[63:32] != 0);
    q = {32'd0, macc} >> sh;
`ifdef PSUM_ROUND_EN
    if (sh != 0) q = ({32'd0, macc} + (64'd1 << (sh - 1))) >> sh;
`endif
    exp_data = (exp_ovf || q > 255) ? 8'hff : q[7:0];

    n = $urandom_range(0, 5);
    for (int s = 0; s < n; s++) begin
      check("out_valid_held", out_valid, 1);
      check("out_data_held", out_data, exp_data);
      check("out_ovf_held", out_ovf, exp_ovf);
      tick();
    end
    out_ready = 1'b1;
    start = 1'b1;
    check("out_valid", out_valid, 1);
    check("out_data", out_data, exp_data);
    check("out_ovf", out_ovf, exp_ovf);
    check("step_ready_in_out", step_ready, 0);
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("idle_after_handshake", busy, 0);
    check("out_valid_dropped", out_valid, 0);
    check("acc_kept_final", psum_to_mac, macc);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_valid = 1'b0; out_ready = 1'b0;
    cfg_len = '0; cfg_shift = '0; psum_from_mac = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    check("rst_step_ready", step_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_psum", psum_to_mac, 0);

    terms = {};
    run_accum(16'd0, 5'd3);

    terms = {64'd10, 64'd10, 64'd15};
    run_accum(16'd3, 5'd2);

    terms = {64'd300, 64'd200};
    run_accum(16'd2, 5'd0);

    terms = {64'hffff_ff00, 64'h110};
    run_accum(16'd2, 5'd4);

    terms = {64'd1, 64'd2, 64'd3, 64'd4};
    run_accum(16'd4, 5'd1);

    // Reset mid-accumulation discards the partial sum.
    start = 1'b1; cfg_len = 16'd5; cfg_shift = 5'd0;
    tick();
    start = 1'b0;
    step_valid = 1'b1; psum_from_mac = 32'd100;
    tick();
    psum_from_mac = 32'd250;
    tick();
    step_valid = 1'b0;
    check("mid_acc_psum", psum_to_mac, 250);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_acc_busy", busy, 0);
    check("rst_acc_psum", psum_to_mac, 0);
    check("rst_acc_out_valid", out_valid, 0);
    check("rst_acc_step_ready", step_ready, 0);

    terms = {64'd7};
    run_accum(16'd1, 5'd0);

    for (int r = 0; r < 25; r++) begin
      int k;
      k = $urandom_range(1, 8);
      terms = {};
      for (int i = 0; i < k; i++) begin
        if ($urandom_range(0, 3) == 0) terms.push_back({32'd0, $urandom});
        else terms.push_back(64'($urandom_range(0, 65025)));
      end
      run_accum(16'(k), 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
